mau_tcam_lookup_ctrl: RTL

Issue-and-align stage that sits directly upstream of the MAU-stage TCAM and consumes its registered results. Accepts search keys with an opaque per-packet tag over a valid/ready handshake and drives the TCAM lookup port. Re-associates each 1-cycle-latency TCAM result with its tag and buffers results in a credit-controlled FIFO. Presents tag plus hit/action to the downstream action stage with backpressure.

---
 rtl/mau_tcam_lookup_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/mau_tcam_lookup_ctrl.sv
// Issue-and-align stage in front of the MAU TCAM: issues lookups, pairs each
// 1-cycle-latency result with its tag, and buffers results for the action stage.
module mau_tcam_lookup_ctrl #(
    parameter int KEY_W      = 512,
    parameter int IDX_W      = 11,
    parameter int TAG_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [KEY_W-1:0] s_key,
    input  logic [TAG_W-1:0] s_tag,
    input  logic             cfg_busy,
    output logic             tcam_lookup_en,
    output logic [KEY_W-1:0] tcam_key,
    input  logic             tcam_hit,
    input  logic [IDX_W-1:0] tcam_hit_idx,
    input  logic [15:0]      tcam_action_id,
    input  logic [15:0]      tcam_action_ptr,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [TAG_W-1:0] m_tag,
    output logic             m_hit,
    output logic [IDX_W-1:0] m_hit_idx,
    output logic [15:0]      m_action_id,
    output logic [15:0]      m_action_ptr,
    output logic [CNT_W-1:0] stat_lookups,
    output logic [CNT_W-1:0] stat_hits,
    output logic             idle
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = TAG_W + 1 + IDX_W + 16 + 16;

    logic             inflight_reg;
    logic [TAG_W-1:0] tag_reg;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]   count_reg, count_next;
    logic [CNT_W-1:0] stat_lookups_reg, stat_hits_reg;
    logic [ENT_W-1:0] mem_reg [FIFO_DEPTH];

    logic             accept, push, pop;
    logic [PTR_W+1:0] credits_used;
    logic [ENT_W-1:0] push_data, head;

    // A lookup holds a credit from accept until its FIFO entry is popped.
    assign credits_used = {1'b0, count_reg} + {{(PTR_W + 1){1'b0}}, inflight_reg};
    assign s_ready      = !cfg_busy && (credits_used < (PTR_W + 2)'(FIFO_DEPTH));
    assign accept       = s_valid && s_ready && !rst;

    assign tcam_lookup_en = accept;
    assign tcam_key       = rst ? '0 : s_key;

    assign push = inflight_reg;
    assign pop  = m_valid && m_ready;

    // Action fields are forced to zero on a miss so downstream never sees stale data.
    assign push_data = {tag_reg, tcam_hit, tcam_hit_idx,
                        tcam_hit ? tcam_action_id  : 16'h0000,
                        tcam_hit ? tcam_action_ptr : 16'h0000};

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_reg     <= 1'b0;
            tag_reg          <= '0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            stat_lookups_reg <= '0;
            stat_hits_reg    <= '0;
        end else begin
            inflight_reg <= accept;
            if (accept) begin
                tag_reg          <= s_tag;
                stat_lookups_reg <= stat_lookups_reg + 1'b1;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (tcam_hit) begin
                    stat_hits_reg <= stat_hits_reg + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    // Payload storage needs no reset: it is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    assign m_valid = (count_reg != '0);
    assign head    = m_valid ? mem_reg[rd_ptr_reg] : '0;
    assign {m_tag, m_hit, m_hit_idx, m_action_id, m_action_ptr} = head;

    assign stat_lookups = stat_lookups_reg;
    assign stat_hits    = stat_hits_reg;
    assign idle         = (count_reg == '0) && !inflight_reg;

endmodule
